// File: rtl/fifo_pkg.sv
// Pointer helpers shared by the async FIFO's write and read domains.
// Inputs and results are 32 bits wide. Zero-extend narrower pointers in and truncate results back.
package fifo_pkg;

    localparam int PTR_MAX = 32;

    function automatic logic [PTR_MAX-1:0] bin2gray(input logic [PTR_MAX-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // The XOR-prefix runs from the MSB down, so zero-extended upper bits leave the result unchanged.
    function automatic logic [PTR_MAX-1:0] gray2bin(input logic [PTR_MAX-1:0] g);
        logic [PTR_MAX-1:0] b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wptr_full_if.sv
// Write-side bundle between the FIFO top level and the write pointer/flag block.
// The slave is the pointer block; the master is the FIFO top level or a bench.
interface wptr_full_if #(
    parameter int ADDRSIZE = 9
);
    logic                winc;
    logic [ADDRSIZE:0]   wq2_rptr;
    logic                wovf_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic                woverflow;

    modport master (
        output winc, wq2_rptr, wovf_clr,
        input  waddr, wptr, wfull, walmost_full, woverflow
    );

    modport slave (
        input  winc, wq2_rptr, wovf_clr,
        output waddr, wptr, wfull, walmost_full, woverflow
    );
endinterface

// File: rtl/wptr_full.sv
// Write pointer (binary + Gray) with registered full/almost-full/overflow; flags update on the same edge as the write.
// A write attempted while wfull is set is dropped, and it latches the sticky woverflow flag.
module wptr_full
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = 9,
    parameter int AF_MARGIN = 4
) (
    input  logic        wclk,
    input  logic        wrst,
    wptr_full_if.slave  bus
);
    localparam int PW    = ADDRSIZE + 1;
    localparam int DEPTH = 1 << ADDRSIZE;

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_wfull;
    logic          r_walmost_full;
    logic          r_woverflow;

    logic          w_winc_ok;
    logic [PW-1:0] w_wbinnext;
    logic [PW-1:0] w_wgraynext;
    logic [PW-1:0] w_full_ptr;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_wocc;

    assign w_winc_ok   = bus.winc && !r_wfull;
    assign w_wbinnext  = r_wbin + PW'(w_winc_ok);
    assign w_wgraynext = PW'(bin2gray(PTR_MAX'(w_wbinnext)));

    // In Gray code, the full pointer is the read pointer with its top two bits inverted.
    assign w_full_ptr  = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
    assign w_rbin      = PW'(gray2bin(PTR_MAX'(bus.wq2_rptr)));
    assign w_wocc      = w_wbinnext - w_rbin;

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_woverflow    <= 1'b0;
        end else begin
            r_wbin         <= w_wbinnext;
            r_wptr         <= w_wgraynext;
            r_wfull        <= (w_wgraynext == w_full_ptr);
            r_walmost_full <= (w_wocc >= PW'(DEPTH - AF_MARGIN));
            if (bus.winc && r_wfull) begin
                r_woverflow <= 1'b1;
            end else if (bus.wovf_clr) begin
                r_woverflow <= 1'b0;
            end
        end
    end

    assign bus.waddr        = r_wbin[ADDRSIZE-1:0];
    assign bus.wptr         = r_wptr;
    assign bus.wfull        = r_wfull;
    assign bus.walmost_full = r_walmost_full;
    assign bus.woverflow    = r_woverflow;

endmodule

// File: tb/tb_wptr_full.sv
// Scoreboarded directed bench for wptr_full at ADDRSIZE=4, DEPTH=16, AF_MARGIN=2.
module tb_wptr_full;
    localparam int ADDRSIZE = 4;

    typedef struct packed {
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic       wfull;
        logic       walmost_full;
        logic       woverflow;
    } obs_t;

    typedef struct {
        int    cyc;
        string name;
        obs_t  v;
    } exp_t;

    logic wclk = 1'b0;
    logic wrst = 1'b1;
    int   cyc  = 0;
    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    wptr_full_if #(.ADDRSIZE(ADDRSIZE)) bus ();

    wptr_full #(.ADDRSIZE(ADDRSIZE), .AF_MARGIN(2)) dut (
        .wclk (wclk),
        .wrst (wrst),
        .bus  (bus)
    );

    always #5 wclk = ~wclk;
    always @(posedge wclk) cyc <= cyc + 1;

    function automatic logic [4:0] g(input int n);
        logic [4:0] b;
        b = 5'(n);
        return b ^ (b >> 1);
    endfunction

    task automatic drive(input logic inc, input logic [4:0] rp, input logic clr);
        bus.winc     = inc;
        bus.wq2_rptr = rp;
        bus.wovf_clr = clr;
        @(posedge wclk);
        #1;
    endtask

    task automatic expect_o(input string nm, input logic [3:0] a, input logic [4:0] p,
                            input logic f, input logic af, input logic ov);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.v    = {a, p, f, af, ov};
        sb.push_back(e);
    endtask

    // Reset lands between clock edges, after the monitor's negedge sample, so the zeros are seen without an edge.
    task automatic async_reset(input string nm);
        @(negedge wclk);
        #3;
        expect_o(nm, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        wrst = 1'b1;
        @(posedge wclk);
        #1;
        wrst         = 1'b0;
        bus.winc     = 1'b0;
        bus.wq2_rptr = '0;
        bus.wovf_clr = 1'b0;
        drive(1'b0, 5'd0, 1'b0);
        expect_o("post_reset", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Monitor: compares every queued expectation whose cycle has arrived.
    initial begin
        exp_t e;
        obs_t got;
        forever begin
            @(negedge wclk or posedge wrst);
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e   = sb.pop_front();
                got = {bus.waddr, bus.wptr, bus.wfull, bus.walmost_full, bus.woverflow};
                n_checks++;
                if (got === e.v && e.cyc == cyc) begin
                    n_pass++;
                end else begin
                    $display("FAIL %s cyc=%0d: got addr=%0d ptr=%b full=%b af=%b ovf=%b, want addr=%0d ptr=%b full=%b af=%b ovf=%b (queued for cyc %0d)",
                             e.name, cyc, got.waddr, got.wptr, got.wfull, got.walmost_full, got.woverflow,
                             e.v.waddr, e.v.wptr, e.v.wfull, e.v.walmost_full, e.v.woverflow, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.winc     = 1'b0;
        bus.wq2_rptr = '0;
        bus.wovf_clr = 1'b0;
        @(posedge wclk);
        #1;
        expect_o("reset", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        wrst = 1'b0;
        drive(1'b0, 5'd0, 1'b0);
        expect_o("release", 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);

        for (int k = 1; k <= 7; k++) begin
            drive(1'b1, 5'd0, 1'b0);
            expect_o("burst", 4'(k), g(k), 1'b0, 1'b0, 1'b0);
        end
        async_reset("reset_mid_burst");

        for (int n = 1; n <= 16; n++) begin
            drive(1'b1, 5'd0, 1'b0);
            expect_o("fill", 4'(n % 16), g(n), n == 16, n >= 14, 1'b0);
        end

        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd0, 1'b0);
            expect_o("ovf_hold", 4'd0, 5'b11000, 1'b1, 1'b1, 1'b1);
        end
        drive(1'b0, 5'd0, 1'b1);
        expect_o("ovf_clr", 4'd0, 5'b11000, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 5'd0, 1'b1);
        expect_o("ovf_set_wins", 4'd0, 5'b11000, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 5'd0, 1'b0);
        expect_o("ovf_sticky", 4'd0, 5'b11000, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 5'd0, 1'b1);
        expect_o("ovf_clr2", 4'd0, 5'b11000, 1'b1, 1'b1, 1'b0);

        drive(1'b0, 5'b00001, 1'b0);
        expect_o("drain_occ15", 4'd0, 5'b11000, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 5'b00110, 1'b0);
        expect_o("drain_occ12", 4'd0, 5'b11000, 1'b0, 1'b0, 1'b0);

        async_reset("reset_before_wrap");
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, g(k >= 2 ? k - 2 : 0), 1'b0);
            expect_o("wrap", 4'((k + 1) % 16), g(k + 1), 1'b0, 1'b0, 1'b0);
        end

        for (int k = 0; k < 10; k++) begin
            drive(1'b0, g(20), 1'b0);
            expect_o("idle", 4'd4, 5'b11110, 1'b0, 1'b0, 1'b0);
        end

        @(negedge wclk);
        #3;
        if (sb.size() != 0) begin
            $display("FAIL scoreboard_drain: %0d expectations never checked, want 0", sb.size());
            n_checks += sb.size();
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/wptr_full.md
Name: wptr_full

Overview:
- Write-domain pointer and flag generator for the asynchronous FIFO.
- Sits directly upstream of the FIFO memory and drives its write address and full qualifier.
- Keeps the binary and Gray write pointers, and compares against the read pointer already synchronised into wclk to produce registered full, almost-full and overflow flags.
- Exports the Gray write pointer for synchronisation into the read domain.

Parameters:
- ADDRSIZE, 9, memory address bits; DEPTH = 2**ADDRSIZE; legal range ≥ 2.
- AF_MARGIN, 4, almost-full asserts when occupancy ≥ DEPTH − AF_MARGIN; legal range 1..DEPTH−1.

Ports:
- wclk  in  1  write-domain clock.
- wrst  in  1  asynchronous, active-high reset.
- winc  in  1  write request; the write is accepted when winc && !wfull.
- wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already double-synchronised into wclk.
- wovf_clr  in  1  clears the sticky woverflow flag.
- waddr  out  ADDRSIZE  memory write address.
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchroniser.
- wfull  out  1  registered full flag; also the memory write qualifier.
- walmost_full  out  1  registered almost-full flag.
- woverflow  out  1  sticky flag: a write was attempted while full.

Behaviour:
- Reset: wrst asserted asynchronously forces wbin, wptr, wfull, walmost_full and woverflow to 0, so waddr = 0. Release is taken on the next wclk edge. Reset mid-operation discards all pointer state; the read side must be reset together with it.
- Internal state: wbin (ADDRSIZE+1 bits, binary) and wptr (Gray).
- Next-state logic:
  - wbinnext = wbin + (winc && !wfull), modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
  - Each wclk: wbin <= wbinnext, wptr <= wgraynext.
- waddr = wbin[ADDRSIZE-1:0], combinational from the register. An accepted write uses the current address, and the pointer advances on the same edge.
- Full detection:
  - wfull <= (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
  - Full asserts on the same edge as the write that fills the last slot, with no extra latency.
  - Deassertion waits for the read pointer to cross synchronisation (2 wclk plus read-domain latency). This delay is pessimistic and safe.
- Write while full (winc && wfull): the pointer does not move, and the memory write is suppressed by the wfull qualifier.
- Almost-full:
  - rbin = Gray-to-binary(wq2_rptr).
  - wocc = (wbinnext − rbin) mod 2**(ADDRSIZE+1), range 0..DEPTH.
  - walmost_full <= (wocc ≥ DEPTH − AF_MARGIN).
  - walmost_full is always 1 whenever wfull is 1.
- Overflow:
  - woverflow <= 1 when winc && wfull.
  - Otherwise woverflow <= 0 when wovf_clr.
  - Otherwise woverflow holds.
  - If set and clear occur in the same cycle, set wins.
- Wrap-around: the pointer MSB toggles every DEPTH writes. Full and empty stay distinguishable through the extra MSB, and the Gray sequence is continuous across the wrap.
- Simultaneous events: when a write and a read-pointer change arrive in the same cycle, both are folded into the next-state flags. Only wq2_rptr is used, never a raw read-domain signal.
- No combinational path from wq2_rptr to any output; all flags are registered.
- The memory must be exactly DEPTH = 2**ADDRSIZE words; the pointer arithmetic requires a power-of-two depth.

Decomposition:
- Shared package fifo_pkg holds:
  - function bin2gray(ADDRSIZE+1);
  - function gray2bin(ADDRSIZE+1), an XOR-prefix loop;
  - no typedefs beyond parameterised logic vectors.
- No sub-module. The two-flop synchroniser for the read pointer is the existing sibling block, instantiated at FIFO top level and not inside this block.

Test Plan (ADDRSIZE=4, DEPTH=16, AF_MARGIN=2):
- Reset: assert wrst mid-burst with wbin=7 → waddr=0, wptr=0, wfull=0, walmost_full=0, woverflow=0 immediately, without waiting for a clock edge.
- Fill: wq2_rptr=0, 16 consecutive winc → waddr steps 0..15.
  - walmost_full rises on the edge of write 14.
  - wfull rises on the edge of write 16; wptr = 5'b11000 (Gray of 16).
- Overflow: from full, winc=1 for 3 cycles → waddr, wptr and wfull unchanged; woverflow=1 after the first edge.
  - Pulse wovf_clr with winc=0 → woverflow=0.
  - wovf_clr and winc asserted together while full → woverflow stays 1.
- Drain release: from full, set wq2_rptr=Gray(1)=5'b00001 → wfull=0 and walmost_full=1 (occupancy 15) on the next edge.
  - Set wq2_rptr=Gray(4) → walmost_full=0 (occupancy 12).
- Wrap: write 20 entries while wq2_rptr tracks wptr with a 2-cycle lag → waddr sequence 0..15, 0..3.
  - wptr sequence is Gray 16..19 with MSB=1; wptr changes exactly one bit per accepted write; wfull is never asserted.
- Idle: winc=0 for 10 cycles with a constant wq2_rptr → no output toggles.
